// File: rtl/picomips_pkg.sv
// Shared definitions for the picoMIPS fetch path.
//   PSIZE_DEFAULT : default program memory address width
//   ISIZE_DEFAULT : default instruction width
//   DBG_MAX_WAIT  : cycles a debug read may be held off by a running CPU
//   state_t       : fetch controller states
//   age_t         : debug wait counter type
package picomips_pkg;

    localparam int PSIZE_DEFAULT = 6;
    localparam int ISIZE_DEFAULT = 24;
    localparam int DBG_MAX_WAIT  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef logic [$clog2(DBG_MAX_WAIT + 1) - 1:0] age_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus between the fetch controller, program memory, datapath and debug port.
//   master : fetch_ctrl side (drives address, instr, instr_valid, fetch,
//            halted, dbg_ack, dbg_data)
//   slave  : system side (drives en, I, stall, branch, branch_off,
//            halt_req, dbg_req, dbg_addr)
interface fetch_ctrl_if
    import picomips_pkg::*;
#(
    parameter int Psize = PSIZE_DEFAULT,
    parameter int Isize = ISIZE_DEFAULT
) ();

    logic             en;
    logic [Psize-1:0] address;
    logic [Isize-1:0] I;
    logic [Isize-1:0] instr;
    logic             instr_valid;
    logic             fetch;
    logic             stall;
    logic             branch;
    logic [Psize-1:0] branch_off;
    logic             halt_req;
    logic             dbg_req;
    logic [Psize-1:0] dbg_addr;
    logic             dbg_ack;
    logic [Isize-1:0] dbg_data;
    logic             halted;

    modport master (
        input  en, I, stall, branch, branch_off, halt_req, dbg_req, dbg_addr,
        output address, instr, instr_valid, fetch, dbg_ack, dbg_data, halted
    );

    modport slave (
        output en, I, stall, branch, branch_off, halt_req, dbg_req, dbg_addr,
        input  address, instr, instr_valid, fetch, dbg_ack, dbg_data, halted
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller with a shared debug read port.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : fetch_ctrl_if.master -- program memory address/data, datapath
//           handshake (stall, branch, halt_req, instr, instr_valid, fetch),
//           debug read port (dbg_req/dbg_addr -> dbg_ack/dbg_data), halted
// The program memory is shared: a debug grant steals the address mux for one
// cycle, so the CPU does not fetch in that cycle.
module fetch_ctrl
    import picomips_pkg::*;
#(
    parameter int Psize = PSIZE_DEFAULT,
    parameter int Isize = ISIZE_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);

    localparam age_t AGE_MAX = age_t'(DBG_MAX_WAIT);

    state_t           state;
    logic [Psize-1:0] pc;
    logic [Psize-1:0] pc_next;
    age_t             age;
    logic [Isize-1:0] instr;
    logic             instr_valid;
    logic             dbg_ack;
    logic [Isize-1:0] dbg_data;
    logic             dbg_grant;
    logic             fetch;

    // Debug wins immediately whenever the CPU is not using memory; while
    // running it waits at most AGE_MAX cycles before stealing one cycle.
    assign dbg_grant = bus.dbg_req & ((state != RUN) | bus.stall | (age == AGE_MAX));
    assign fetch     = (state == RUN) & ~bus.stall & ~dbg_grant;

    // halt_req takes priority over branch; sums wrap modulo 2^Psize.
    always_comb begin
        // NOTE: default assignment first so every path drives pc_next and no latch is inferred.
        pc_next = pc;
        if (bus.halt_req)
            pc_next = pc;
        else if (bus.branch)
            pc_next = pc + bus.branch_off;
        else
            pc_next = pc + 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            dbg_ack     <= 1'b0;
            dbg_data    <= '0;
            age         <= '0;
        end else begin
            instr_valid <= fetch;
            dbg_ack     <= dbg_grant;

            if (fetch) begin
                instr <= bus.I;
                pc    <= pc_next;
            end

            if (dbg_grant)
                dbg_data <= bus.I;

            if (!bus.dbg_req || dbg_grant)
                age <= '0;
            else if (age != AGE_MAX)
                age <= age + 1'b1;

            case (state)
                IDLE: if (bus.en) state <= RUN;
                RUN: begin
                    // A halting fetch still completes; en=0 acts at this edge too.
                    if (fetch && bus.halt_req)
                        state <= HALT;
                    else if (!bus.en)
                        state <= IDLE;
                end
                HALT: if (!bus.en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.address     = dbg_grant ? bus.dbg_addr : pc;
    assign bus.fetch       = fetch;
    assign bus.instr       = instr;
    assign bus.instr_valid = instr_valid;
    assign bus.dbg_ack     = dbg_ack;
    assign bus.dbg_data    = dbg_data;
    assign bus.halted      = (state == HALT);

endmodule
